// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage register slice.
//   occ_state_e    : occupancy state of a pipe_skid_reg (0/1/2 entries held)
//   CTRL_W_DEF     : default control payload width
//   DATA_W_DEF     : default data payload width
//   CTRL_*         : bit positions of the EX/MEM control signals in the ctrl field
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

  localparam int CTRL_W_DEF = 8;
  localparam int DATA_W_DEF = 107;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_TO_REG = 1;
  localparam int CTRL_BRANCH     = 2;
  localparam int CTRL_MEM_READ   = 3;
  localparam int CTRL_MEM_WRITE  = 4;

endpackage

// File: rtl/pipe_slot.sv
// One payload register with synchronous clear and load enables.
//   clk_i, rst_i : clock, synchronous active-high reset (clears to 0)
//   clr_i        : zero the register (wins over ld_i)
//   ld_i         : capture d_i
//   d_i / q_o    : payload in / registered payload out
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (ld_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with a 2-entry skid buffer, valid/ready on both
// sides, synchronous flush and a saturating stall counter.
//   clk_i, rst_i              : clock, synchronous active-high reset
//   flush_i                   : drop every held entry
//   in_valid_i / in_ready_o   : upstream handshake (ready is registered)
//   in_ctrl_i, in_data_i      : upstream payload
//   out_valid_o / out_ready_i : downstream handshake
//   out_ctrl_o, out_data_o    : main entry payload, zero when not valid
//   occ_o                     : entries held (0/1/2)
//   stall_cnt_o               : saturating count of valid-but-not-ready cycles
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int PW = CTRL_W + DATA_W;

  occ_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic in_fire, out_fire;
  logic main_ld, main_clr, skid_ld, skid_clr, main_from_skid;
  logic [PW-1:0] in_pl, main_din, main_q, skid_q;

  assign in_pl    = {in_ctrl_i, in_data_i};
  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) state_d = ST_HALF;
        ST_HALF: begin
          if (out_fire && !in_fire)      state_d = ST_EMPTY;
          else if (in_fire && !out_fire) state_d = ST_FULL;
        end
        ST_FULL:  if (out_fire) state_d = ST_HALF;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Output / datapath control
  always_comb begin
    main_ld        = 1'b0;
    main_clr       = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    main_from_skid = 1'b0;
    if (flush_i) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: main_ld = in_fire;
        ST_HALF: begin
          if (in_fire && out_fire) main_ld  = 1'b1;
          else if (out_fire)       main_clr = 1'b1;
          else if (in_fire)        skid_ld  = 1'b1;
        end
        ST_FULL: begin
          if (out_fire) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  assign main_din = main_from_skid ? skid_q : in_pl;

  // Stall counter: saturates, cleared only by reset
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid_o && !out_ready_i && !flush_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  pipe_slot #(.W(PW)) u_main (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (main_clr),
    .ld_i  (main_ld),
    .d_i   (main_din),
    .q_o   (main_q)
  );

  pipe_slot #(.W(PW)) u_skid (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (skid_clr),
    .ld_i  (skid_ld),
    .d_i   (in_pl),
    .q_o   (skid_q)
  );

  // Main slot is zeroed whenever the stage is empty, so bubbles read as 0
  assign in_ready_o  = (state_q != ST_FULL);
  assign out_valid_o = (state_q != ST_EMPTY);
  assign occ_o       = state_q;
  assign out_ctrl_o  = main_q[PW-1:DATA_W];
  assign out_data_o  = main_q[DATA_W-1:0];
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

  localparam int CW = 8;
  localparam int DW = 107;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } pl_t;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          in_ready, out_valid, in_ready_s, out_valid_s;
  logic [CW-1:0] out_ctrl, out_ctrl_s;
  logic [DW-1:0] out_data, out_data_s;
  logic [1:0]    occ, occ_s;
  logic [15:0]   stall;
  logic [2:0]    stall_s;

  int n_chk = 0;
  int n_err = 0;

  // Reference: a FIFO of at most two payloads plus an unbounded stall tally
  pl_t         mq[$];
  int unsigned mstall;

  always #5 clk = ~clk;

  pipe_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_ctrl_i(in_ctrl), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_ctrl_o(out_ctrl), .out_data_o(out_data),
    .occ_o(occ), .stall_cnt_o(stall)
  );

  pipe_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(3)) dut_sat (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready_s),
    .in_ctrl_i(in_ctrl), .in_data_i(in_data),
    .out_valid_o(out_valid_s), .out_ready_i(out_ready),
    .out_ctrl_o(out_ctrl_s), .out_data_o(out_data_s),
    .occ_o(occ_s), .stall_cnt_o(stall_s)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [CW-1:0] c, input logic [DW-1:0] d, input logic ordy);
    bit  ifire, ofire, stl;
    pl_t p, e;
    int unsigned e16, e3;
    rst = r; flush = f; in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy;
    ifire = iv && (mq.size() < 2);
    ofire = (mq.size() > 0) && ordy;
    stl   = (mq.size() > 0) && !ordy && !f;
    @(posedge clk);
    if (r) begin
      mq.delete();
      mstall = 0;
    end else begin
      if (stl) mstall++;
      if (ofire) void'(mq.pop_front());
      if (f) mq.delete();
      else if (ifire) begin
        p.c = c; p.d = d;
        mq.push_back(p);
      end
    end
    #1;
    e   = (mq.size() > 0) ? mq[0] : '0;
    e16 = (mstall > 65535) ? 65535 : mstall;
    e3  = (mstall > 7) ? 7 : mstall;
    check("occ",       128'(occ),       128'(mq.size()));
    check("in_ready",  128'(in_ready),  128'(mq.size() < 2));
    check("out_valid", 128'(out_valid), 128'(mq.size() > 0));
    check("out_ctrl",  128'(out_ctrl),  128'(e.c));
    check("out_data",  128'(out_data),  128'(e.d));
    check("stall16",   128'(stall),     128'(e16));
    check("stall3",    128'(stall_s),   128'(e3));
    check("data_sat",  128'(out_data_s), 128'(e.d));
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    mstall = 0;

    // Reset state
    step(1, 0, 0, '0, '0, 0);
    step(0, 0, 0, '0, '0, 1);

    // Streaming 1..4 at full throughput
    for (int i = 1; i <= 4; i++) step(0, 0, 1, 8'(i), DW'(i), 1);
    step(0, 0, 0, '0, '0, 1);

    // Back-pressure: A, B fill, C held off, then drain in order
    step(0, 0, 1, 8'h0A, DW'('h11), 0);
    step(0, 0, 1, 8'h0B, DW'('h22), 0);
    step(0, 0, 1, 8'h0C, DW'('h33), 0);
    step(0, 0, 1, 8'h0C, DW'('h33), 1);
    step(0, 0, 1, 8'h0C, DW'('h33), 1);
    step(0, 0, 0, '0, '0, 1);
    step(0, 0, 0, '0, '0, 1);

    // Flush while full with an input offered
    step(0, 0, 1, 8'h01, DW'('h44), 0);
    step(0, 0, 1, 8'h02, DW'('h55), 0);
    step(0, 1, 1, 8'h03, DW'('h66), 0);
    step(0, 0, 0, '0, '0, 1);

    // Bubble zeroing after consuming ctrl=FF
    step(0, 0, 1, 8'hFF, '1, 1);
    step(0, 0, 0, '0, '0, 1);
    step(0, 0, 0, '0, '0, 1);

    // Reset mid-operation with stall count 5
    step(1, 0, 0, '0, '0, 0);
    step(0, 0, 1, 8'h21, DW'('h77), 0);
    step(0, 0, 1, 8'h22, DW'('h88), 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, '0, 0);
    step(1, 0, 1, 8'h23, DW'('h99), 0);

    // Saturation of the 3-bit counter
    step(0, 0, 1, 8'h31, DW'('hAA), 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, '0, '0, 0);
    step(0, 0, 0, '0, '0, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 5),
           ($urandom_range(0, 99) < 70), 8'($urandom), rnd_data(),
           ($urandom_range(0, 99) < 60));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised pipeline-stage register that succeeds the fixed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control field and a data field between stages using a valid/ready handshake.
- Provides a 2-entry skid buffer, so back-pressure is absorbed without a combinational ready path.
- Supports synchronous flush for branch/hazard squash and keeps a saturating stall counter for performance debug.

Parameters:
- CTRL_W, 8: width of control payload (RegWrite, MemtoReg, Branch, MemRead, MemWrite, ...); forced to 0 on bubble or flush.
- DATA_W, 107: width of data payload (PC sum, ALU result, RT data, RD index, zero flag, ...).
- CNT_W, 16: width of the stall counter.

Ports:
- clk_i, input, 1: clock; all state updates on rising edge.
- rst_i, input, 1: synchronous reset, active-high.
- flush_i, input, 1: synchronous squash of all held entries.
- in_valid_i, input, 1: upstream has a payload.
- in_ready_o, output, 1: stage accepts a payload this cycle (registered).
- in_ctrl_i, input, CTRL_W: upstream control payload.
- in_data_i, input, DATA_W: upstream data payload.
- out_valid_o, output, 1: main entry holds a payload.
- out_ready_i, input, 1: downstream accepts this cycle.
- out_ctrl_o, output, CTRL_W: main entry control; 0 whenever out_valid_o=0.
- out_data_o, output, DATA_W: main entry data; 0 whenever out_valid_o=0.
- occ_o, output, 2: occupancy, 0/1/2.
- stall_cnt_o, output, CNT_W: saturating count of stalled cycles.

Behaviour:
- Transfers:
  - in_fire = in_valid_i & in_ready_o.
  - out_fire = out_valid_o & out_ready_i.
- Storage: main register (drives outputs) and skid register; every output comes straight from a flop.
- States:
  - EMPTY (occ 0): in_ready_o=1, out_valid_o=0.
  - HALF (occ 1): in_ready_o=1, out_valid_o=1.
  - FULL (occ 2): in_ready_o=0, out_valid_o=1.
- EMPTY:
  - in_fire -> main<=in, go to HALF.
  - Otherwise stay in EMPTY.
- HALF:
  - in_fire & out_fire -> main<=in, stay in HALF. This is full throughput: 1 payload/cycle, latency 1 cycle.
  - out_fire only -> main cleared to 0, go to EMPTY.
  - in_fire only -> skid<=in, go to FULL.
  - Neither -> hold.
- FULL:
  - out_fire -> main<=skid, skid cleared, go to HALF.
  - Otherwise hold.
  - in_valid_i is ignored in FULL.
- Ordering: payloads leave strictly in arrival order and are never duplicated or dropped, except on flush.
- Bubble rule: whenever out_valid_o=0, both out_ctrl_o and out_data_o are 0, so legacy consumers that ignore valid see a no-op.
- flush_i=1 at an edge:
  - Next state is EMPTY; main and skid are zeroed.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle still counts as consumed by downstream.
  - Flush overrides every transition.
- Reset (rst_i=1 at an edge), highest priority:
  - State EMPTY, all payload flops 0, stall_cnt_o=0.
  - Values after the reset edge: in_ready_o=1, out_valid_o=0, out_ctrl_o=0, out_data_o=0, occ_o=0.
  - A reset asserted mid-transfer discards all held entries.
- stall_cnt_o:
  - Increments when out_valid_o=1 and out_ready_i=0, and not in reset or flush.
  - Saturates at 2^CNT_W-1; cleared only by rst_i.
- occ_o is derived from the registered state encoding; no combinational path from out_ready_i to in_ready_o.

Decomposition:
- Shared package pipe_pkg:
  - Occupancy state enum {ST_EMPTY=2'd0, ST_HALF=2'd1, ST_FULL=2'd2}.
  - Default widths CTRL_W_DEF and DATA_W_DEF.
  - Control-field bit-position constants for EX/MEM usage.
- Sub-module pipe_slot: one clearable payload register with load/clear enables. Instantiated twice (main, skid).
- FSM, handshake and counter live in the top module.

Test Plan:
- Streaming: reset, then in_valid_i=1 with out_ready_i=1 and data 1,2,3,4 on consecutive cycles -> out_data_o 1,2,3,4 one cycle later each; occ_o stays 1; stall_cnt_o=0.
- Back-pressure: load A=0x11, hold out_ready_i=0, send B=0x22 -> occ_o=2, in_ready_o=0 next cycle, C held off. Raise out_ready_i -> outputs 0x11, 0x22, then C in order.
- Flush: occ_o=2 with in_valid_i=1 and flush_i=1 -> next cycle occ_o=0, out_valid_o=0, out_ctrl_o=0, out_data_o=0; the flushed-cycle input never appears.
- Bubble zeroing: single payload ctrl=8'hFF consumed, then in_valid_i=0 -> out_ctrl_o=0 and out_data_o=0 on the following cycle.
- Reset mid-operation: occ_o=2, stall_cnt_o=5, rst_i=1 for one edge -> occ_o=0, in_ready_o=1, stall_cnt_o=0, all outputs 0.
- Saturation: CNT_W=3, out_ready_i=0 for 10 cycles with a valid payload -> stall_cnt_o climbs to 7 and holds at 7.
